// File: rtl/chain_pkg.sv
// Shared types and default sizes for the anchor-chaining scheduler.
package chain_pkg;

   localparam int DEPTH = 64;
   localparam int IDXW  = 16;

   // "No predecessor" marker; users keep the low IDXW bits.
   localparam logic [31:0] NO_PRED = '1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      EMIT
   } state_e;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] w;
      logic [31:0] f;
   } anchor_t;

endpackage

// File: rtl/chain_anchor_buf.sv
// Anchor history buffer: DEPTH entries, one write port, one async read port.
module chain_anchor_buf #(
   parameter int DEPTH = chain_pkg::DEPTH
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  chain_pkg::anchor_t       wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output chain_pkg::anchor_t       rd_data
);
   import chain_pkg::*;

   // Contents need no reset: the scheduler's count says which slots are live.
   anchor_t mem_q [DEPTH];

   // Single write port, shared by anchor load and f write-back.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/chain_scheduler.sv
// Anchor-chaining DP sequencer: walks predecessors of each new anchor,
// feeds (i, j) pairs to the external score unit and reduces the returned
// scores into f(i) and the best predecessor p(i).
//
// state | meaning
// IDLE  | ready for a new anchor; load it into the buffer
// ISSUE | one predecessor j per cycle onto sc_*, tag pushed into the pipe
// DRAIN | waiting for the last in-flight score to be reduced
// EMIT  | result held on out_*; write f(i) back on out_ready
module chain_scheduler #(
   parameter int DEPTH     = chain_pkg::DEPTH,
   parameter int MAX_PRED  = 32,
   parameter int MAX_DIST  = 5000,
   parameter int SCORE_LAT = 5,
   parameter int IDXW      = chain_pkg::IDXW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_x,
   input  logic [31:0]     in_y,
   input  logic [31:0]     in_w,
   input  logic            in_last,
   input  logic [31:0]     W_avg,
   output logic [31:0]     sc_riX,
   output logic [31:0]     sc_riY,
   output logic [31:0]     sc_qiX,
   output logic [31:0]     sc_qiY,
   output logic [31:0]     sc_W,
   output logic [31:0]     sc_W_avg,
   input  logic [31:0]     sc_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [IDXW-1:0] out_idx,
   output logic [31:0]     out_f,
   output logic [IDXW-1:0] out_p
);
   import chain_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [IDXW-1:0] NO_PRED_I = NO_PRED[IDXW-1:0];

   state_e          state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [IDXW-1:0] j_q, j_d;
   logic [IDXW-1:0] best_p_q, best_p_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   walk_q, walk_d;
   logic            last_q, last_d;
   logic [31:0]     cur_x_q, cur_x_d, cur_y_q, cur_y_d, cur_w_q, cur_w_d;
   logic [31:0]     best_f_q, best_f_d;
   logic [31:0]     sc_rix_q, sc_rix_d, sc_riy_q, sc_riy_d;
   logic [31:0]     sc_qix_q, sc_qix_d, sc_qiy_q, sc_qiy_d;
   logic [31:0]     sc_w_q, sc_w_d, sc_wavg_q, sc_wavg_d;

   // Tag pipe: stage SCORE_LAT-1 lines up with sc_result for that issue.
   // f(j) travels alongside so the single buffer read port stays on the walk.
   logic            tag_occ_q [SCORE_LAT];
   logic            tag_vld_q [SCORE_LAT];
   logic [IDXW-1:0] tag_j_q   [SCORE_LAT];
   logic [31:0]     tag_f_q   [SCORE_LAT];
   logic            push_occ, push_vld;
   logic [IDXW-1:0] push_j;
   logic [31:0]     push_f;

   logic            buf_wr_en;
   logic [AW-1:0]   buf_wr_addr, buf_rd_addr;
   anchor_t         buf_wr_data, buf_rd_data;

   logic [CW-1:0]   k_init;
   logic [31:0]     x_gap, cand;
   logic            stop_walk, pair_ok, pipe_drained;

   chain_anchor_buf #(.DEPTH(DEPTH)) u_buf (
      .clk     (clk),
      .wr_en   (buf_wr_en),
      .wr_addr (buf_wr_addr),
      .wr_data (buf_wr_data),
      .rd_addr (buf_rd_addr),
      .rd_data (buf_rd_data)
   );

   // Slot i is read back in EMIT so the f write-back keeps x, y, w intact.
   assign buf_rd_addr = (state_q == EMIT) ? idx_q[AW-1:0] : j_q[AW-1:0];

   assign k_init    = (count_q > CW'(MAX_PRED)) ? CW'(MAX_PRED) : count_q;
   assign x_gap     = cur_x_q - buf_rd_data.x;
   assign stop_walk = (cur_x_q > buf_rd_data.x) && (x_gap > 32'(MAX_DIST));
   assign pair_ok   = (buf_rd_data.x < cur_x_q) && (buf_rd_data.y < cur_y_q);
   assign cand      = tag_f_q[SCORE_LAT-1] + sc_result;

   // Pipe counts as empty once only the exiting stage may still be occupied;
   // that tag is reduced this cycle, so EMIT can follow directly.
   always_comb begin
      pipe_drained = 1'b1;
      for (int s = 0; s < SCORE_LAT - 1; s++) begin
         if (tag_occ_q[s]) pipe_drained = 1'b0;
      end
   end

   // Next-state, reduction, buffer port control and handshake outputs.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      j_d         = j_q;
      count_d     = count_q;
      walk_d      = walk_q;
      last_d      = last_q;
      cur_x_d     = cur_x_q;
      cur_y_d     = cur_y_q;
      cur_w_d     = cur_w_q;
      best_f_d    = best_f_q;
      best_p_d    = best_p_q;
      sc_rix_d    = sc_rix_q;
      sc_riy_d    = sc_riy_q;
      sc_qix_d    = sc_qix_q;
      sc_qiy_d    = sc_qiy_q;
      sc_w_d      = sc_w_q;
      sc_wavg_d   = sc_wavg_q;
      push_occ    = 1'b0;
      push_vld    = 1'b0;
      push_j      = j_q;
      push_f      = buf_rd_data.f;
      buf_wr_en   = 1'b0;
      buf_wr_addr = idx_q[AW-1:0];
      buf_wr_data = '{x: buf_rd_data.x, y: buf_rd_data.y, w: buf_rd_data.w, f: best_f_q};
      in_ready    = 1'b0;
      out_valid   = 1'b0;

      // Strict compare: on a tie the earlier-exiting (nearer) j is kept.
      if (tag_occ_q[SCORE_LAT-1] && tag_vld_q[SCORE_LAT-1] &&
          ($signed(cand) > $signed(best_f_q))) begin
         best_f_d = cand;
         best_p_d = tag_j_q[SCORE_LAT-1];
      end

      case (state_q)
         IDLE: begin
            in_ready = reset;
            if (in_valid && reset) begin
               buf_wr_en   = 1'b1;
               buf_wr_data = '{x: in_x, y: in_y, w: in_w, f: in_w};
               cur_x_d     = in_x;
               cur_y_d     = in_y;
               cur_w_d     = in_w;
               last_d      = in_last;
               best_f_d    = in_w;
               best_p_d    = NO_PRED_I;
               j_d         = idx_q - IDXW'(1);
               walk_d      = k_init;
               state_d     = (k_init != '0) ? ISSUE : EMIT;
            end
         end
         ISSUE: begin
            if (stop_walk) begin
               state_d = pipe_drained ? EMIT : DRAIN;
            end else begin
               sc_rix_d  = cur_x_q;
               sc_riy_d  = buf_rd_data.x;
               sc_qix_d  = cur_y_q;
               sc_qiy_d  = buf_rd_data.y;
               sc_w_d    = cur_w_q;
               sc_wavg_d = W_avg;
               push_occ  = 1'b1;
               push_vld  = pair_ok;
               j_d       = j_q - IDXW'(1);
               walk_d    = walk_q - CW'(1);
               if (walk_q == CW'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pipe_drained) state_d = EMIT;
         end
         EMIT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               buf_wr_en = 1'b1;
               idx_d     = idx_q + IDXW'(1);
               count_d   = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
               if (last_q) begin
                  idx_d   = '0;
                  count_d = '0;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         j_q       <= '0;
         count_q   <= '0;
         walk_q    <= '0;
         last_q    <= 1'b0;
         cur_x_q   <= '0;
         cur_y_q   <= '0;
         cur_w_q   <= '0;
         best_f_q  <= '0;
         best_p_q  <= '0;
         sc_rix_q  <= '0;
         sc_riy_q  <= '0;
         sc_qix_q  <= '0;
         sc_qiy_q  <= '0;
         sc_w_q    <= '0;
         sc_wavg_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         j_q       <= j_d;
         count_q   <= count_d;
         walk_q    <= walk_d;
         last_q    <= last_d;
         cur_x_q   <= cur_x_d;
         cur_y_q   <= cur_y_d;
         cur_w_q   <= cur_w_d;
         best_f_q  <= best_f_d;
         best_p_q  <= best_p_d;
         sc_rix_q  <= sc_rix_d;
         sc_riy_q  <= sc_riy_d;
         sc_qix_q  <= sc_qix_d;
         sc_qiy_q  <= sc_qiy_d;
         sc_w_q    <= sc_w_d;
         sc_wavg_q <= sc_wavg_d;
      end
   end

   // Tag pipe shifts every cycle; reset discards anything in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < SCORE_LAT; s++) begin
            tag_occ_q[s] <= 1'b0;
            tag_vld_q[s] <= 1'b0;
            tag_j_q[s]   <= '0;
            tag_f_q[s]   <= '0;
         end
      end else begin
         tag_occ_q[0] <= push_occ;
         tag_vld_q[0] <= push_vld;
         tag_j_q[0]   <= push_j;
         tag_f_q[0]   <= push_f;
         for (int s = 1; s < SCORE_LAT; s++) begin
            tag_occ_q[s] <= tag_occ_q[s-1];
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_j_q[s]   <= tag_j_q[s-1];
            tag_f_q[s]   <= tag_f_q[s-1];
         end
      end
   end

   assign sc_riX   = sc_rix_q;
   assign sc_riY   = sc_riy_q;
   assign sc_qiX   = sc_qix_q;
   assign sc_qiY   = sc_qiy_q;
   assign sc_W     = sc_w_q;
   assign sc_W_avg = sc_wavg_q;
   assign out_idx  = idx_q;
   assign out_f    = best_f_q;
   assign out_p    = best_p_q;

endmodule

// File: doc/chain_scheduler.md
# chain_scheduler

Sequencing controller for the anchor-chaining DP in the DSA datapath. It accepts a stream of x-sorted anchors and buffers the last DEPTH of them. For each new anchor i it walks its predecessors j = i-1, i-2, … and issues one (i, j) pair per cycle to the free-running pairwise score unit. It aligns the returned scores by fixed latency and reduces them to f(i) and the best predecessor p(i), which it emits downstream.

## Interface
Parameters:
- DEPTH, 64: anchor buffer entries; power of two.
- MAX_PRED, 32: maximum predecessors walked per anchor; ≤ DEPTH-1.
- MAX_DIST, 5000: maximum x distance; the walk stops early beyond it.
- SCORE_LAT, 5: cycles from operand presentation to the matching sc_result.
- IDXW, 16: anchor index width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- in_valid / in_ready  in / out  1  anchor input handshake.
- in_x, in_y, in_w  in  32  anchor ref coord, query coord, span.
- in_last  in  1  last anchor of the chain; index counter and buffer clear after its emit.
- W_avg  in  32  passed unchanged to sc_W_avg.
- sc_riX, sc_riY, sc_qiX, sc_qiY, sc_W, sc_W_avg  out  32  score-unit operands: x_i, x_j, y_i, y_j, w_i, W_avg.
- sc_result  in  32  score, two's-complement signed, valid SCORE_LAT cycles after issue.
- out_valid / out_ready  out / in  1  result handshake.
- out_idx  out  IDXW  index i.
- out_f  out  32  signed f(i).
- out_p  out  IDXW  best predecessor, or NO_PRED (all ones).

## Operation
- States are IDLE, ISSUE, DRAIN and EMIT.
  - IDLE: in_ready=1. On handshake, write the anchor into slot idx mod DEPTH, set best_f=in_w and best_p=NO_PRED, then set k = min(MAX_PRED, count). Go to ISSUE if k>0, else EMIT.
  - ISSUE: one j per cycle, from i-1 downward. Register the operands onto sc_*.
    - If x_i - x_j > MAX_DIST, stop without issuing that j.
    - A pair is marked valid only if x_j < x_i and y_j < y_i. Invalid pairs still consume their cycle but are tagged invalid.
    - After the last issue, or on early stop, go to DRAIN.
  - DRAIN: wait until the tag shift register (depth SCORE_LAT, carrying valid and j) is empty, then go to EMIT.
  - EMIT: out_valid=1 with out_idx, out_f and out_p held stable until out_ready. Write best_f into the f field of slot i, then increment idx and count (count saturates at DEPTH). If in_last, clear idx and count. Return to IDLE.
- Reduction, each cycle a valid tag exits: cand = f(j) + sc_result, a 32-bit signed wrapping add. If cand > best_f (strict), update best_f=cand and best_p=j. Ties keep the nearer j.
- sc_result is ignored whenever the exiting tag is invalid, including the unit's post-reset zeros.

## Timing
- Reset values: in_ready=0 during reset, 1 in the first cycle after release (IDLE). out_valid=0, out_idx=out_f=out_p=0, all sc_*=0, count=idx=0, tags cleared.
- sc_* hold their last issued value outside ISSUE.
- Anchor accepted at cycle t with k>0 walked:
  - issues occur at t+1 … t+k;
  - the last result is reduced at t+k+SCORE_LAT;
  - out_valid rises at t+k+SCORE_LAT+1.
- With k=0, out_valid rises at t+1.
- An early stop at the m-th candidate means m-1 issues; timing follows with k=m-1.
- Back-pressure: out_ready low stalls in EMIT indefinitely. in_ready stays low outside IDLE.
- Reset asserted mid-operation aborts immediately: in-flight tags are discarded and the buffer is logically empty.
- Index wrap: idx wraps modulo 2^IDXW. Buffer addressing uses idx mod DEPTH.

## Structure
- Package chain_pkg holds DEPTH, IDXW, NO_PRED, the state enum, and the anchor_t struct {x, y, w, f}.
- Sub-module chain_anchor_buf: DEPTH-entry register array. One write port shared by load and f update, with the two writes never occurring in the same cycle. One async read port for j.

## Test plan
- Single anchor (100, 200, w=15) with in_last=1 → out_f=15, out_p=NO_PRED, out_valid at t+1; next anchor gets idx 0.
- Anchors (100,200,15) then (110,210,15); bench score model returns 12 after SCORE_LAT → second result out_f=27, out_p=0, out_valid at t+1+5+1.
- Three anchors; scores returned for j=1 and j=0 are equal, giving equal candidates → out_p=1 (nearer wins).
- Predecessor with y_j ≥ y_i, bench returning score 1000 → ignored, out_f=w_i, out_p=NO_PRED.
- Anchor at x=10000 following x=100 with MAX_DIST=5000 → zero issues, out_valid at t+2.
- Assert reset mid-ISSUE, then replay the first scenario → identical result; out_ready held low for 10 cycles → outputs stable and in_ready=0 throughout.
